loop_filter: RTL and testbench
==============================

Name: loop_filter

Overview:
Digital PI loop filter for the GPSDO. It consumes each 16-bit offset-binary frequency-error word (DIFF, centred at 32767) and its ready flag from the PPS-gated main counter. It computes a saturated tuning word for the OCXO control DAC and raises a lock indicator. It sits between the main counter and the DAC interface, entirely in the CLK (10 MHz OCXO) domain.

Parameters:
DAC_W, 16, width of DAC tuning word
DAC_MID, 32768, DAC code at reset and PI zero point
CENTER, 32767, DIFF value meaning zero frequency error
KP_SH, 2, proportional gain = 2^KP_SH (left shift)
KI_SH, 4, integral gain = 2^-KI_SH (arithmetic right shift of accumulator)
DEADBAND, 0, |err| <= DEADBAND is treated as zero error
LOCK_TOL, 2, |err| <= LOCK_TOL counts as an in-tolerance sample
LOCK_CNT, 16, consecutive in-tolerance samples required to assert LOCKED
INVERT, 0, 0: positive err lowers DAC code; 1: positive err raises it

Ports:
CLK  in  1  system clock (OCXO)
CLR_N  in  1  synchronous active-low reset
DIFF  in  16  offset-binary error word from main counter; stable while RDY high
RDY  in  1  ready flag from main counter (PPS domain, asynchronous to CLK)
HOLD  in  1  holdover: discard new samples, freeze DAC code
DAC_CODE  out  DAC_W  tuning word to DAC interface
DAC_STB  out  1  one-cycle pulse when DAC_CODE updates
LOCKED  out  1  loop-locked indicator

Behaviour:
- One clock; reset is synchronous and active-low. While CLR_N=0 at a CLK edge, all of the following take their reset values: DAC_CODE=DAC_MID, DAC_STB=0, LOCKED=0, integrator=0, lock counter=0, sat flags=0, sync flops=0, armed=0, FSM=IDLE.
- A reset mid-computation aborts the computation. No strobe is issued for the aborted sample.
- RDY passes through a 2-flop synchroniser. A new sample is the rising edge of the synchronised RDY. DIFF is captured only after synchronisation; it is quasi-static by then.
- Upstream must run with MULT>=1 so that RDY returns low between samples.
- The first detected edge after reset is discarded: it only sets armed and produces no strobe.
- Edges arriving while the FSM is not in IDLE are dropped.
- FSM: IDLE -> CAPT -> ERR -> INTEG -> SUM -> CLAMP -> OUT -> IDLE.
  - IDLE: on edge && armed && !HOLD, go to CAPT. On edge && HOLD, discard the sample, clear LOCKED and the lock counter, and stay in IDLE.
  - CAPT: register DIFF.
  - ERR: err = {1'b0,DIFF} - CENTER, 17-bit signed, range -32767..+32768.
    - e = 0 if |err| <= DEADBAND.
    - Otherwise e = -err (INVERT=0) or e = err (INVERT=1).
  - INTEG: integ = integ + e, 32-bit signed, saturating at +/-(2^31-1).
    - Anti-windup: skip the update if the previous output clamped high and e>0.
    - Likewise skip it if the previous output clamped low and e<0.
  - SUM: s = DAC_MID + (e <<< KP_SH) + (integ >>> KI_SH), evaluated 40-bit signed. The shift is arithmetic, so it floors toward -inf.
  - CLAMP: s<0 -> 0 and set sat_lo. s>2^DAC_W-1 -> 2^DAC_W-1 and set sat_hi. Otherwise pass s through and clear both flags.
  - OUT: register DAC_CODE, pulse DAC_STB for exactly one cycle, update the lock state.
- Latency: if RDY is first sampled high at edge t0, DAC_CODE and DAC_STB change at edge t0+7. DAC_STB is low again at t0+8.
- Lock logic uses raw err, before the deadband is applied.
  - |err| <= LOCK_TOL: increment the counter, saturating at LOCK_CNT.
  - Otherwise: clear the counter.
  - LOCKED = (counter == LOCK_CNT), updated at the same edge as DAC_STB.
- HOLD is sampled only in IDLE. Changing HOLD mid-computation has no effect on the current sample.
- DAC_CODE holds its value between strobes and throughout HOLD.

Test Plan:
1. Reset, RDY held high across reset release, DIFF=32767 -> that first edge is discarded, no DAC_STB, DAC_CODE=32768.
2. Next RDY rising edge (first sampled high at edge t0), DIFF=32767 -> DAC_STB high only at edge t0+7, DAC_CODE=32768, LOCKED=0.
3. From reset-armed state, DIFF=32777 (err=+10), repeated for two samples -> first sample: integ=-10, DAC_CODE=32768-40-1=32727; second sample: integ=-20, DAC_CODE=32768-40-2=32726.
4. DIFF=0 (err=-32767), repeated for two samples -> first sample: DAC_CODE=65535, sat_hi set, integ=32767; second sample: integ stays 32767 (anti-windup), DAC_CODE=65535.
5. 16 consecutive samples with DIFF=32768 (err=+1) -> LOCKED rises with the 16th DAC_STB. A 17th sample with DIFF=32770 (err=+3) -> LOCKED falls with that strobe.
6. HOLD=1 at a sample edge -> no DAC_STB, DAC_CODE unchanged, LOCKED=0. Separately, CLR_N pulsed low at t0+4 of a sample -> no strobe at t0+7, DAC_CODE=32768.

Source files
------------

// File: rtl/loop_filter_if.sv
// rtl/loop_filter_if.sv - sample/DAC bundle between main counter, loop filter and DAC interface
//   DIFF     : offset-binary frequency-error word, stable while RDY high
//   RDY      : sample-ready flag (asynchronous to CLK)
//   HOLD     : holdover request, freezes the DAC code
//   DAC_CODE : tuning word to the DAC interface
//   DAC_STB  : one-cycle pulse on each DAC_CODE update
//   LOCKED   : loop-locked indicator
interface loop_filter_if #(
   parameter int DAC_W = 16
);
   logic [15:0]      DIFF;
   logic             RDY;
   logic             HOLD;
   logic [DAC_W-1:0] DAC_CODE;
   logic             DAC_STB;
   logic             LOCKED;

   modport master (
      output DIFF, RDY, HOLD,
      input  DAC_CODE, DAC_STB, LOCKED
   );

   modport slave (
      input  DIFF, RDY, HOLD,
      output DAC_CODE, DAC_STB, LOCKED
   );
endinterface

// File: rtl/loop_filter.sv
// rtl/loop_filter.sv - GPSDO PI loop filter: frequency error in, saturated OCXO DAC tuning word out
//   CLK   : system clock (10 MHz OCXO)
//   CLR_N : synchronous active-low reset
//   bus   : loop_filter_if.slave (DIFF/RDY/HOLD in, DAC_CODE/DAC_STB/LOCKED out)
module loop_filter #(
   parameter int DAC_W    = 16,
   parameter int DAC_MID  = 32768,
   parameter int CENTER   = 32767,
   parameter int KP_SH    = 2,
   parameter int KI_SH    = 4,
   parameter int DEADBAND = 0,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 16,
   parameter int INVERT   = 0
) (
   input logic          CLK,
   input logic          CLR_N,
   loop_filter_if.slave bus
);
   localparam int CW = $clog2(LOCK_CNT + 1);

   localparam logic signed [32:0] C_IMAX = 33'sd2147483647;
   localparam logic signed [32:0] C_IMIN = -33'sd2147483647;
   localparam logic signed [39:0] C_MID  = 40'(DAC_MID);
   localparam logic signed [39:0] C_DMAX = 40'((64'd1 << DAC_W) - 64'd1);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPT, S_ERR, S_INTEG, S_SUM, S_CLAMP, S_OUT
   } state_t;

   state_t             r_state;
   logic               r_sync1, r_sync2, r_sync2_d;
   logic               r_armed;
   logic [15:0]        r_diff;
   logic signed [16:0] r_e;
   logic               r_in_tol;
   logic signed [31:0] r_integ;
   logic signed [39:0] r_sum;
   logic               r_sat_hi, r_sat_lo;
   logic [CW-1:0]      r_lock_cnt;
   logic [DAC_W-1:0]   r_dac;
   logic               r_stb;
   logic               r_locked;

   logic               w_edge;
   logic signed [16:0] w_err;
   logic [16:0]        w_abs_err;
   logic signed [16:0] w_e;
   logic signed [32:0] w_isum;
   logic signed [31:0] w_integ_next;
   logic               w_windup;
   logic signed [39:0] w_e40, w_i40, w_sum;
   logic [CW-1:0]      w_cnt_next;

   // rising edge of the synchronised ready flag
   assign w_edge = r_sync2 & ~r_sync2_d;

   assign w_err     = $signed({1'b0, r_diff}) - $signed(17'(CENTER));
   assign w_abs_err = w_err[16] ? 17'(-w_err) : 17'(w_err);

   always_comb begin
      w_e = '0;
      if (w_abs_err > 17'(DEADBAND))
         w_e = (INVERT != 0) ? w_err : -w_err;
   end

   // 33-bit sum cannot overflow, so saturation is a plain range check
   assign w_isum = {r_integ[31], r_integ} + {{16{r_e[16]}}, r_e};

   always_comb begin
      w_integ_next = w_isum[31:0];
      if (w_isum > C_IMAX)
         w_integ_next = 32'sh7FFF_FFFF;
      else if (w_isum < C_IMIN)
         w_integ_next = 32'sh8000_0001;
   end

   // stop the integrator pushing further into a rail the output is already on
   assign w_windup = (r_sat_hi && (r_e > 17'sd0)) || (r_sat_lo && (r_e < 17'sd0));

   assign w_e40 = {{23{r_e[16]}}, r_e};
   assign w_i40 = {{8{r_integ[31]}}, r_integ};
   assign w_sum = C_MID + (w_e40 <<< KP_SH) + (w_i40 >>> KI_SH);

   always_comb begin
      w_cnt_next = '0;
      if (r_in_tol)
         w_cnt_next = (r_lock_cnt == CW'(LOCK_CNT)) ? r_lock_cnt : r_lock_cnt + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         r_state    <= S_IDLE;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_sync2_d  <= 1'b0;
         r_armed    <= 1'b0;
         r_diff     <= '0;
         r_e        <= '0;
         r_in_tol   <= 1'b0;
         r_integ    <= '0;
         r_sum      <= '0;
         r_sat_hi   <= 1'b0;
         r_sat_lo   <= 1'b0;
         r_lock_cnt <= '0;
         r_dac      <= DAC_W'(DAC_MID);
         r_stb      <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         r_sync1   <= bus.RDY;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         r_stb     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  if (!r_armed)
                     r_armed <= 1'b1;          // first edge after reset may be a stale RDY level
                  else if (bus.HOLD) begin
                     r_locked   <= 1'b0;
                     r_lock_cnt <= '0;
                  end else
                     r_state <= S_CAPT;
               end
            end
            S_CAPT: begin
               r_diff  <= bus.DIFF;
               r_state <= S_ERR;
            end
            S_ERR: begin
               r_e      <= w_e;
               r_in_tol <= (w_abs_err <= 17'(LOCK_TOL));
               r_state  <= S_INTEG;
            end
            S_INTEG: begin
               if (!w_windup)
                  r_integ <= w_integ_next;
               r_state <= S_SUM;
            end
            S_SUM: begin
               r_sum   <= w_sum;
               r_state <= S_CLAMP;
            end
            S_CLAMP: begin
               // result is registered on entry to OUT so the strobe lands seven edges after RDY
               if (r_sum < 40'sd0) begin
                  r_dac    <= '0;
                  r_sat_lo <= 1'b1;
                  r_sat_hi <= 1'b0;
               end else if (r_sum > C_DMAX) begin
                  r_dac    <= '1;
                  r_sat_lo <= 1'b0;
                  r_sat_hi <= 1'b1;
               end else begin
                  r_dac    <= r_sum[DAC_W-1:0];
                  r_sat_lo <= 1'b0;
                  r_sat_hi <= 1'b0;
               end
               r_stb      <= 1'b1;
               r_lock_cnt <= w_cnt_next;
               r_locked   <= (w_cnt_next == CW'(LOCK_CNT));
               r_state    <= S_OUT;
            end
            S_OUT: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.DAC_CODE = r_dac;
   assign bus.DAC_STB  = r_stb;
   assign bus.LOCKED   = r_locked;
endmodule

// File: tb/tb_loop_filter.sv
// tb/tb_loop_filter.sv - directed-vector bench for loop_filter
`timescale 1ns/1ps
module tb_loop_filter;
   logic clk;
   logic clr_n;

   loop_filter_if #(.DAC_W(16)) bus ();

   loop_filter dut (
      .CLK   (clk),
      .CLR_N (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [15:0] diff;
      logic [15:0] dac;
      bit          locked;
      string       name;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp;
   int   n_err;
   int   s_cnt;
   int   s_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input bit rst, input logic [15:0] diff,
                               input logic [15:0] dac, input bit locked, input string name);
      vec_t v;
      v.rst = rst; v.diff = diff; v.dac = dac; v.locked = locked; v.name = name;
      tbl.push_back(v);
   endfunction

   // reset with RDY held high across release: that edge must only arm the filter
   task automatic rst_arm();
      int cnt;
      clr_n    = 1'b0;
      bus.RDY  = 1'b1;
      bus.HOLD = 1'b0;
      bus.DIFF = 16'd32767;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dac", 32'(bus.DAC_CODE), 32'd32768);
      check("rst_stb", 32'(bus.DAC_STB), 32'd0);
      check("rst_locked", 32'(bus.LOCKED), 32'd0);
      clr_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.DAC_STB) cnt++;
      end
      check("arm_no_stb", 32'(cnt), 32'd0);
      bus.RDY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // k=0 is the edge that first samples RDY high; a strobe is expected at k=7
   task automatic do_sample(input logic [15:0] diff, input bit hold, input int hold_k,
                            output int cnt, output int cyc);
      cnt = 0;
      cyc = -1;
      bus.DIFF = diff;
      bus.HOLD = hold;
      bus.RDY  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.DAC_STB) begin
            cnt++;
            cyc = k;
         end
         if (k == hold_k) bus.HOLD = 1'b1;
      end
      bus.RDY  = 1'b0;
      bus.HOLD = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      clr_n    = 1'b0;
      bus.RDY  = 1'b0;
      bus.HOLD = 1'b0;
      bus.DIFF = 16'd32767;

      add(1, 16'd32767, 16'd32768, 0, "zero_err");
      add(1, 16'd32777, 16'd32727, 0, "err10_a");
      add(0, 16'd32777, 16'd32726, 0, "err10_b");
      add(1, 16'd0,     16'd65535, 0, "sat_hi_a");
      add(0, 16'd0,     16'd65535, 0, "sat_hi_b");
      add(0, 16'd32767, 16'd34815, 0, "windup_hi");
      add(1, 16'd65535, 16'd0,     0, "sat_lo_a");
      add(0, 16'd65535, 16'd0,     0, "sat_lo_b");
      add(0, 16'd32767, 16'd30720, 0, "windup_lo");
      for (int i = 1; i <= 16; i++)
         add(i == 1, 16'd32768, 16'd32763, i == 16, $sformatf("lock_%0d", i));
      add(0, 16'd32770, 16'd32754, 0, "unlock");

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) rst_arm();
         do_sample(tbl[i].diff, 1'b0, -1, s_cnt, s_cyc);
         check({tbl[i].name, "_stb_cnt"}, 32'(s_cnt), 32'd1);
         check({tbl[i].name, "_stb_cyc"}, 32'(s_cyc), 32'd7);
         check({tbl[i].name, "_dac"}, 32'(bus.DAC_CODE), 32'(tbl[i].dac));
         check({tbl[i].name, "_locked"}, 32'(bus.LOCKED), 32'(tbl[i].locked));
      end

      // holdover after lock: sample dropped, code frozen, lock cleared
      rst_arm();
      for (int i = 0; i < 16; i++) do_sample(16'd32768, 1'b0, -1, s_cnt, s_cyc);
      check("pre_hold_locked", 32'(bus.LOCKED), 32'd1);
      do_sample(16'd32768, 1'b1, -1, s_cnt, s_cyc);
      check("hold_no_stb", 32'(s_cnt), 32'd0);
      check("hold_dac", 32'(bus.DAC_CODE), 32'd32763);
      check("hold_locked", 32'(bus.LOCKED), 32'd0);
      do_sample(16'd32768, 1'b0, -1, s_cnt, s_cyc);
      check("post_hold_stb", 32'(s_cnt), 32'd1);
      check("post_hold_dac", 32'(bus.DAC_CODE), 32'd32762);
      check("post_hold_locked", 32'(bus.LOCKED), 32'd0);

      // reset sampled at t0+4 aborts the sample; RDY still high re-arms only
      s_cnt = 0;
      bus.DIFF = 16'd32777;
      bus.RDY  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.DAC_STB) s_cnt++;
         if (k == 3) clr_n = 1'b0;
         if (k == 4) clr_n = 1'b1;
      end
      bus.RDY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_stb", 32'(s_cnt), 32'd0);
      check("abort_dac", 32'(bus.DAC_CODE), 32'd32768);
      check("abort_locked", 32'(bus.LOCKED), 32'd0);
      do_sample(16'd32767, 1'b0, -1, s_cnt, s_cyc);
      check("after_abort_stb", 32'(s_cnt), 32'd1);
      check("after_abort_dac", 32'(bus.DAC_CODE), 32'd32768);

      // HOLD raised after the sample was accepted does not cancel it
      do_sample(16'd32777, 1'b0, 2, s_cnt, s_cyc);
      check("late_hold_stb_cnt", 32'(s_cnt), 32'd1);
      check("late_hold_stb_cyc", 32'(s_cyc), 32'd7);
      check("late_hold_dac", 32'(bus.DAC_CODE), 32'd32727);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
